// File: rtl/axis_mt19937_checker_if.sv
// ---------------------------------------------------------------------------
// axis_mt19937_checker_if
// AXI4-Stream bundle carrying 32-bit MT19937 output words.
//   tdata  : received word
//   tvalid : upstream has a word on tdata
//   tready : sink can accept a word this cycle
// master drives tdata/tvalid, slave drives tready.
// ---------------------------------------------------------------------------
interface axis_mt19937_checker_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_mt19937_checker.sv
// ---------------------------------------------------------------------------
// axis_mt19937_checker
// Stream integrity monitor for a 32-bit MT19937 output stream. The first 624
// accepted words are untempered into a local copy of the generator state;
// after a two-cycle prefetch the block predicts every following word and
// compares it against the received one.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   input_axis   : AXI4-Stream sink (tdata/tvalid in, tready out)
//   clear        : synchronous restart, zeroes counters, drops the word
//   locked       : state rebuilt, comparison active
//   mismatch     : one-cycle pulse after a compared word differed
//   error_count  : saturating count of mismatching words
//   word_count   : saturating count of compared words
// ---------------------------------------------------------------------------
module axis_mt19937_checker #(
  parameter int COUNT_WIDTH = 32,
  parameter bit AUTO_RESYNC = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  axis_mt19937_checker_if.slave    input_axis,
  input  logic                     clear,
  output logic                     locked,
  output logic                     mismatch,
  output logic [COUNT_WIDTH-1:0]   error_count,
  output logic [COUNT_WIDTH-1:0]   word_count
);

  localparam int          N        = 624;
  localparam logic [9:0]  LAST     = 10'd623;
  localparam logic [9:0]  OFFSET_M = 10'd397;
  localparam logic [31:0] MATRIX_A = 32'h9908B0DF;
  localparam logic [31:0] TEMPER_B = 32'h9D2C5680;
  localparam logic [31:0] TEMPER_C = 32'hEFC60000;

  typedef enum logic [1:0] {S_CAPTURE, S_PRIME, S_CHECK} state_t;

  state_t      state;
  logic        tready_r;
  logic        prime_cnt;
  logic [9:0]  ptr_i;
  logic [9:0]  ptr_a;
  logic [9:0]  ptr_b;

  logic [31:0] mt_ram [0:N-1];
  logic [31:0] mt_cur;
  logic [31:0] rd_a;
  logic [31:0] rd_b;

  logic        xfer;
  logic        cap_xfer;
  logic        chk_xfer;
  logic        miss;
  logic        we;
  logic [31:0] y_mix;
  logic [31:0] new_word;
  logic [31:0] expected;
  logic [31:0] wdata;
  logic [9:0]  raddr_a;
  logic [9:0]  raddr_b;

  function automatic logic [9:0] wrap_inc(input logic [9:0] p);
    return (p == LAST) ? 10'd0 : p + 10'd1;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  function automatic logic [31:0] temper(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v >> 11);
    t = t ^ ((t << 7) & TEMPER_B);
    t = t ^ ((t << 15) & TEMPER_C);
    t = t ^ (t >> 18);
    return t;
  endfunction

  // Shift-by-18 and shift-by-15 steps are self-inverse; the 7 and 11 steps
  // recover a few more correct bits per iteration until all 32 settle.
  function automatic logic [31:0] untemper(input logic [31:0] v);
    logic [31:0] t;
    logic [31:0] r;
    t = v ^ (v >> 18);
    t = t ^ ((t << 15) & TEMPER_C);
    r = t;
    for (int k = 0; k < 5; k++) r = t ^ ((r << 7) & TEMPER_B);
    t = r;
    for (int k = 0; k < 3; k++) r = t ^ (r >> 11);
    return r;
  endfunction

  assign input_axis.tready = tready_r;

  assign xfer     = input_axis.tvalid & tready_r & ~clear;
  assign cap_xfer = xfer & (state == S_CAPTURE);
  assign chk_xfer = xfer & (state == S_CHECK);

  assign y_mix    = {mt_cur[31], rd_a[30:0]};
  assign new_word = rd_b ^ (y_mix >> 1) ^ (y_mix[0] ? MATRIX_A : 32'h0);
  assign expected = temper(new_word);
  assign miss     = chk_xfer & (input_axis.tdata != expected);

  assign we    = cap_xfer | chk_xfer;
  assign wdata = cap_xfer ? untemper(input_axis.tdata) : new_word;

  // Read ports run one step ahead on a transfer so the registered data is
  // already aligned with the next index. The first PRIME cycle fetches mt[0]
  // through port A; it is then parked in mt_cur.
  assign raddr_a = (state == S_PRIME && !prime_cnt) ? ptr_i :
                   (chk_xfer ? wrap_inc(ptr_a) : ptr_a);
  assign raddr_b = chk_xfer ? wrap_inc(ptr_b) : ptr_b;

  // ---- state RAM and read registers ----
  always_ff @(posedge clk) begin
    if (we) mt_ram[ptr_i] <= wdata;
    rd_a <= mt_ram[raddr_a];
    rd_b <= mt_ram[raddr_b];
    // mt[i+1] becomes the next mt[i]; it is never rewritten before use.
    if ((state == S_PRIME && prime_cnt) || chk_xfer) mt_cur <= rd_a;
  end

  // ---- control FSM and counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_CAPTURE;
      tready_r    <= 1'b0;
      prime_cnt   <= 1'b0;
      locked      <= 1'b0;
      mismatch    <= 1'b0;
      error_count <= '0;
      word_count  <= '0;
      ptr_i       <= '0;
      ptr_a       <= 10'd1;
      ptr_b       <= OFFSET_M;
    end else if (clear) begin
      state       <= S_CAPTURE;
      tready_r    <= 1'b1;
      prime_cnt   <= 1'b0;
      locked      <= 1'b0;
      mismatch    <= 1'b0;
      error_count <= '0;
      word_count  <= '0;
      ptr_i       <= '0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        S_CAPTURE: begin
          tready_r <= 1'b1;
          if (cap_xfer) begin
            if (ptr_i == LAST) begin
              state     <= S_PRIME;
              tready_r  <= 1'b0;
              prime_cnt <= 1'b0;
              ptr_i     <= '0;
              ptr_a     <= 10'd1;
              ptr_b     <= OFFSET_M;
            end else begin
              ptr_i <= ptr_i + 10'd1;
            end
          end
        end
        S_PRIME: begin
          prime_cnt <= 1'b1;
          if (prime_cnt) begin
            state    <= S_CHECK;
            tready_r <= 1'b1;
            locked   <= 1'b1;
          end
        end
        S_CHECK: begin
          if (chk_xfer) begin
            word_count <= sat_inc(word_count);
            if (miss) begin
              mismatch    <= 1'b1;
              error_count <= sat_inc(error_count);
            end
            if (AUTO_RESYNC && miss) begin
              state  <= S_CAPTURE;
              locked <= 1'b0;
              ptr_i  <= '0;
            end else begin
              ptr_i <= wrap_inc(ptr_i);
              ptr_a <= wrap_inc(ptr_a);
              ptr_b <= wrap_inc(ptr_b);
            end
          end
        end
        default: begin
          state  <= S_CAPTURE;
          locked <= 1'b0;
          ptr_i  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_mt19937_checker.sv
// ---------------------------------------------------------------------------
// tb_axis_mt19937_checker
// Drives two checkers (AUTO_RESYNC=0 and AUTO_RESYNC=1) with the MT19937
// stream for seed 5489, produced by a reference generator in the bench.
// A table of scenarios gives word count, corrupted word, valid duty and the
// expected final status; hand-written sequences cover prime timing, the
// mismatch pulse, clear and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_axis_mt19937_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        locked0, mismatch0, locked1, mismatch1;
  logic [31:0] err0, wc0, err1, wc1;

  axis_mt19937_checker_if ax0 ();
  axis_mt19937_checker_if ax1 ();

  axis_mt19937_checker #(.COUNT_WIDTH(32), .AUTO_RESYNC(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .input_axis(ax0), .clear(clear),
    .locked(locked0), .mismatch(mismatch0), .error_count(err0), .word_count(wc0)
  );

  axis_mt19937_checker #(.COUNT_WIDTH(32), .AUTO_RESYNC(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .input_axis(ax1), .clear(clear),
    .locked(locked1), .mismatch(mismatch1), .error_count(err1), .word_count(wc1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses0 = 0;
  int pulses1 = 0;

  always @(negedge clk) begin
    if (mismatch0 === 1'b1) pulses0++;
    if (mismatch1 === 1'b1) pulses1++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, limit %0d", 1500000);
    $fatal(1, "timeout");
  end

  // ---- reference MT19937 generator ----
  logic [31:0] g_mt [0:623];
  int          g_idx;

  task automatic gen_seed(input logic [31:0] s);
    g_mt[0] = s;
    for (int i = 1; i < 624; i++)
      g_mt[i] = 32'd1812433253 * (g_mt[i-1] ^ (g_mt[i-1] >> 30)) + 32'(i);
    g_idx = 624;
  endtask

  task automatic gen_next(output logic [31:0] o);
    logic [31:0] y;
    if (g_idx >= 624) begin
      for (int i = 0; i < 624; i++) begin
        y = (g_mt[i] & 32'h80000000) | (g_mt[(i+1)%624] & 32'h7fffffff);
        g_mt[i] = g_mt[(i+397)%624] ^ (y >> 1) ^ (y[0] ? 32'h9908b0df : 32'h0);
      end
      g_idx = 0;
    end
    y = g_mt[g_idx];
    g_idx++;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9d2c5680);
    y = y ^ ((y << 15) & 32'hefc60000);
    y = y ^ (y >> 18);
    o = y;
  endtask

  // ---- helpers ----
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic get_rdy(input int d);
    return (d == 0) ? ax0.tready : ax1.tready;
  endfunction
  function automatic logic get_locked(input int d);
    return (d == 0) ? locked0 : locked1;
  endfunction
  function automatic logic [31:0] get_err(input int d);
    return (d == 0) ? err0 : err1;
  endfunction
  function automatic logic [31:0] get_wc(input int d);
    return (d == 0) ? wc0 : wc1;
  endfunction
  function automatic int get_pulses(input int d);
    return (d == 0) ? pulses0 : pulses1;
  endfunction

  task automatic set_bus(input int d, input logic v, input logic [31:0] data);
    if (d == 0) begin ax0.tvalid = v; ax0.tdata = data; end
    else        begin ax1.tvalid = v; ax1.tdata = data; end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input int d, input logic [31:0] data);
    int waited;
    waited = 0;
    set_bus(d, 1'b1, data);
    while (get_rdy(d) !== 1'b1 && waited <= 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited > 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: tready low for %0d cycles, expected at most %0d", waited, 50);
    end else begin
      @(negedge clk);
    end
    set_bus(d, 1'b0, data);
  endtask

  task automatic feed(input int d, input int n, input int corrupt_at, input int duty);
    logic [31:0] w;
    gen_seed(32'd5489);
    for (int k = 1; k <= n; k++) begin
      gen_next(w);
      if (k == corrupt_at) w = w ^ 32'h1;
      if (duty < 100)
        while ($urandom_range(0, 99) >= duty) @(negedge clk);
      send(d, w);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear = 1'b0;
    set_bus(0, 1'b0, 32'h0);
    set_bus(1, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    int dut;
    int n_words;
    int corrupt_at;
    int duty;
    bit exp_locked;
    int exp_err;
    int exp_wc;
    int exp_pulses;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [31:0] w;
    int p_start;

    vecs[0] = '{0,   624,   0, 100, 1'b1, 0,    0, 0};
    vecs[1] = '{0, 10000,   0, 100, 1'b1, 0, 9376, 0};
    vecs[2] = '{0, 10000,   0,  30, 1'b1, 0, 9376, 0};
    vecs[3] = '{0,  1000, 700, 100, 1'b1, 1,  376, 1};
    vecs[4] = '{1,  1000, 700, 100, 1'b0, 1,   76, 1};
    vecs[5] = '{1,  2000, 700, 100, 1'b1, 1,  752, 1};
    vecs[6] = '{1,  2000,   0,  30, 1'b1, 0, 1376, 0};

    rst_n = 1'b0;
    clear = 1'b0;
    set_bus(0, 1'b0, 32'h0);
    set_bus(1, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    // ---- reset state, prime timing, mismatch pulse (dut0) ----
    #1;
    check("rst_tready",   ax0.tready, 0);
    check("rst_locked",   locked0,    0);
    check("rst_mismatch", mismatch0,  0);
    check("rst_err",      err0,       0);
    check("rst_wc",       wc0,        0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", ax0.tready, 1);

    p_start = pulses0;
    gen_seed(32'd5489);
    gen_next(w);
    check("model_word1", w, 32'hD091BB5C);
    send(0, w);
    for (int k = 2; k <= 624; k++) begin
      gen_next(w);
      send(0, w);
    end
    gen_next(w);
    set_bus(0, 1'b1, w);
    check("prime_rdy_c0",    ax0.tready, 0);
    check("prime_locked_c0", locked0,    0);
    @(negedge clk);
    check("prime_rdy_c1",    ax0.tready, 0);
    @(negedge clk);
    check("lock_rdy",        ax0.tready, 1);
    check("lock_locked",     locked0,    1);
    check("lock_err",        err0,       0);
    send(0, w);
    check("w625_mismatch", mismatch0, 0);
    check("w625_wc",       wc0,       1);
    gen_next(w);
    send(0, w ^ 32'h1);
    check("bad_mismatch", mismatch0, 1);
    check("bad_err",      err0,      1);
    check("bad_wc",       wc0,       2);
    @(negedge clk);
    check("bad_pulse_end", mismatch0, 0);
    for (int k = 627; k <= 700; k++) begin
      gen_next(w);
      send(0, w);
    end
    @(negedge clk);
    check("after_bad_err",    err0,              1);
    check("after_bad_wc",     wc0,               76);
    check("after_bad_pulses", pulses0 - p_start, 1);

    // ---- scenario table ----
    for (int i = 0; i < 7; i++) begin
      do_reset();
      p_start = get_pulses(vecs[i].dut);
      feed(vecs[i].dut, vecs[i].n_words, vecs[i].corrupt_at, vecs[i].duty);
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_locked", i), get_locked(vecs[i].dut), vecs[i].exp_locked);
      check($sformatf("v%0d_err", i),    get_err(vecs[i].dut),    vecs[i].exp_err);
      check($sformatf("v%0d_wc", i),     get_wc(vecs[i].dut),     vecs[i].exp_wc);
      check($sformatf("v%0d_pulses", i), get_pulses(vecs[i].dut) - p_start, vecs[i].exp_pulses);
    end

    // ---- clear mid-capture ----
    do_reset();
    feed(0, 300, 0, 100);
    gen_next(w);
    clear = 1'b1;
    set_bus(0, 1'b1, w);
    @(negedge clk);
    clear = 1'b0;
    set_bus(0, 1'b0, w);
    check("clr_cap_rdy",    ax0.tready, 1);
    check("clr_cap_locked", locked0,    0);
    check("clr_cap_wc",     wc0,        0);
    feed(0, 700, 650, 100);
    repeat (4) @(negedge clk);
    check("relock_a_locked", locked0, 1);
    check("relock_a_err",    err0,    1);
    check("relock_a_wc",     wc0,     76);

    // ---- clear mid-check ----
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_chk_rdy",      ax0.tready, 1);
    check("clr_chk_locked",   locked0,    0);
    check("clr_chk_err",      err0,       0);
    check("clr_chk_wc",       wc0,        0);
    check("clr_chk_mismatch", mismatch0,  0);
    feed(0, 650, 0, 100);
    repeat (4) @(negedge clk);
    check("relock_b_locked", locked0, 1);
    check("relock_b_err",    err0,    0);
    check("relock_b_wc",     wc0,     26);

    // ---- asynchronous reset while checking ----
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_locked", locked0,    0);
    check("arst_wc",     wc0,        0);
    check("arst_err",    err0,       0);
    check("arst_rdy",    ax0.tready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    feed(0, 634, 0, 100);
    repeat (4) @(negedge clk);
    check("arst_relock_locked", locked0, 1);
    check("arst_relock_wc",     wc0,     10);
    check("arst_relock_err",    err0,    0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
